// File: rtl/lbp_hist_pkg.sv
// rtl/lbp_hist_pkg.sv - shared types and constants for the LBP histogram
package lbp_hist_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_BIN_W  = 8;
  localparam int DEF_CNT_W  = 14;
  localparam int DEF_ADDR_W = 14;

  // Pixel coordinates are 7 bits each; 0 and 127 are the image border.
  localparam int             COORD_W   = 7;
  localparam logic [COORD_W-1:0] BORDER_LO = 7'd0;
  localparam logic [COORD_W-1:0] BORDER_HI = 7'd127;

endpackage

// File: rtl/lbp_hist_sat_inc.sv
// rtl/lbp_hist_sat_inc.sv - saturating +1 incrementer
module sat_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = (&a) ? a : a + 1'b1;

endmodule

// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - 256-bin LBP code histogram with valid/ready drain
module lbp_hist
  import lbp_hist_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [BIN_W-1:0]  lbp_data,
  input  logic              finish,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [BIN_W-1:0]  hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic [CNT_W-1:0]  total,
  output logic              border_err,
  output logic              hist_done
);

  localparam int NBINS = 1 << BIN_W;

  state_t             state;
  logic [CNT_W-1:0]   cnt [NBINS];
  logic [CNT_W-1:0]   bin_inc;
  logic [CNT_W-1:0]   total_inc;
  logic [BIN_W-1:0]   next_bin;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               on_border;

  assign x         = lbp_addr[COORD_W-1:0];
  assign y         = lbp_addr[2*COORD_W-1:COORD_W];
  assign on_border = (x == BORDER_LO) || (x == BORDER_HI) ||
                     (y == BORDER_LO) || (y == BORDER_HI);
  assign next_bin  = hist_bin + 1'b1;

  // Only one bin changes per cycle, so a single incrementer serves the array.
  sat_inc #(.W(CNT_W)) u_bin_inc (
    .a (cnt[lbp_data]),
    .y (bin_inc)
  );

  sat_inc #(.W(CNT_W)) u_total_inc (
    .a (total),
    .y (total_inc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACCUM;
      hist_valid <= 1'b0;
      hist_bin   <= '0;
      hist_count <= '0;
      total      <= '0;
      border_err <= 1'b0;
      hist_done  <= 1'b0;
      for (int i = 0; i < NBINS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          if (lbp_valid) begin
            cnt[lbp_data] <= bin_inc;
            total         <= total_inc;
            if (on_border) begin
              border_err <= 1'b1;
            end
          end
          if (finish) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // First DRAIN cycle loads bin 0 after the last code has landed.
          if (!hist_valid) begin
            hist_valid <= 1'b1;
            hist_bin   <= '0;
            hist_count <= cnt[0];
          end else if (hist_ready) begin
            if (&hist_bin) begin
              hist_valid <= 1'b0;
              hist_done  <= 1'b1;
              state      <= DONE;
            end else begin
              hist_bin   <= next_bin;
              hist_count <= cnt[next_bin];
            end
          end
        end
        DONE: begin
          hist_valid <= 1'b0;
          hist_done  <= 1'b1;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - self-checking bench for lbp_hist
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_valid;
  logic        hist_ready;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic [13:0] total;
  logic        border_err;
  logic        hist_done;

  int n_total = 0;
  int n_bad   = 0;
  int model [256];
  int model_total;
  bit model_border;
  bit model_accum;
  int q_bin [$];
  int q_cnt [$];
  int sum;

  localparam int SAT = 16383;

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .total      (total),
    .border_err (border_err),
    .hist_done  (hist_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 0;
    model_total  = 0;
    model_border = 0;
    model_accum  = 1;
    q_bin.delete();
    q_cnt.delete();
  endtask

  task automatic do_reset();
    reset      = 1;
    lbp_valid  = 0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 0;
    hist_ready = 0;
    tick();
    reset = 0;
    clear_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hist_valid"}, hist_valid, 0);
    check({tag, "_hist_bin"},   hist_bin,   0);
    check({tag, "_hist_count"}, hist_count, 0);
    check({tag, "_total"},      total,      0);
    check({tag, "_border_err"}, border_err, 0);
    check({tag, "_hist_done"},  hist_done,  0);
  endtask

  // Drives one code for one cycle; finish_now also raises finish on that edge.
  task automatic send(input logic [13:0] a, input logic [7:0] d, input bit finish_now);
    int xx;
    int yy;
    lbp_valid = 1;
    lbp_addr  = a;
    lbp_data  = d;
    if (finish_now) finish = 1;
    if (model_accum) begin
      xx = int'(a[6:0]);
      yy = int'(a[13:7]);
      if (model[d] < SAT) model[d]++;
      if (model_total < SAT) model_total++;
      if (xx == 0 || xx == 127 || yy == 0 || yy == 127) model_border = 1;
    end
    tick();
    lbp_valid = 0;
  endtask

  task automatic push_expected();
    model_accum = 0;
    for (int b = 0; b < 256; b++) begin
      q_bin.push_back(b);
      q_cnt.push_back(model[b]);
    end
  endtask

  task automatic raise_finish();
    finish = 1;
    tick();
  endtask

  // Drains with ready always high (bp=0) or the 1,0,0,1 pattern (bp=1);
  // stop_at>=0 returns with the bin stalled when hist_bin reaches it.
  task automatic drain(input bit bp, input int stop_at, output int s);
    int  accepts = 0;
    int  cyc = 0;
    int  pat = 0;
    bit  stalled;
    int  sb;
    int  sc;
    int  eb;
    int  ec;
    s = 0;
    while (accepts < 256 && cyc < 3000) begin
      hist_ready = bp ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'b1;
      pat++;
      if (stop_at >= 0 && hist_valid && int'(hist_bin) == stop_at) begin
        hist_ready = 0;
        return;
      end
      stalled = hist_valid && !hist_ready;
      sb = hist_bin;
      sc = hist_count;
      if (hist_valid && hist_ready) begin
        if (q_bin.size() > 0) begin
          eb = q_bin.pop_front();
          ec = q_cnt.pop_front();
          check("drain_bin", hist_bin, eb);
          check("drain_count", hist_count, ec);
        end else begin
          check("drain_unexpected_bin", hist_bin, -1);
        end
        s += hist_count;
        accepts++;
      end
      tick();
      cyc++;
      if (stalled) begin
        check("stall_valid", hist_valid, 1);
        check("stall_bin", hist_bin, sb);
        check("stall_count", hist_count, sc);
      end
    end
    hist_ready = 0;
    check("drain_accepts", accepts, 256);
    check("done_after_drain", hist_done, 1);
    check("valid_low_after_drain", hist_valid, 0);
  endtask

  initial begin
    do_reset();
    check_reset_outputs("reset");

    // Basic count plus same-bin streak, then a code coincident with finish.
    for (int i = 0; i < 3; i++) send({7'd5, 7'd9}, 8'h1F, 0);
    for (int i = 0; i < 10; i++) send({7'd20, 7'd30}, 8'hFF, 0);
    check("streak_total", total, 13);
    send({7'd40, 7'd40}, 8'h80, 1);
    push_expected();
    check("finish_total", total, model_total);
    check("finish_valid_latency", hist_valid, 0);
    tick();
    check("drain_start_valid", hist_valid, 1);
    check("drain_start_bin", hist_bin, 0);
    check("drain_not_done", hist_done, 0);
    drain(0, -1, sum);
    check("basic_sum", sum, 14);
    send(14'h0000, 8'h33, 0);
    check("done_ignores_total", total, 14);
    check("done_ignores_border", border_err, 0);

    // Full interior frame with backpressured drain.
    do_reset();
    for (int yy = 1; yy <= 126; yy++) begin
      for (int xx = 1; xx <= 126; xx++) begin
        send({yy[6:0], xx[6:0]}, 8'($urandom_range(0, 255)), 0);
      end
    end
    raise_finish();
    push_expected();
    check("frame_total", total, 15876);
    check("frame_border", border_err, 0);
    drain(1, -1, sum);
    check("frame_sum", sum, 15876);

    // Border code is flagged and counted; then reset in the middle of a drain.
    do_reset();
    send(14'h0000, 8'h05, 0);
    check("border_set", border_err, 1);
    check("border_counted", total, 1);
    send({7'd64, 7'd127}, 8'h05, 0);
    raise_finish();
    push_expected();
    check("border_total", total, model_total);
    tick();
    drain(0, 100, sum);
    check("mid_drain_bin", hist_bin, 100);
    reset = 1;
    tick();
    check_reset_outputs("mid_reset");
    reset = 0;
    finish = 0;
    clear_model();

    // Fresh frame after the mid-drain reset counts from zero.
    send({7'd3, 7'd3}, 8'h10, 0);
    send({7'd4, 7'd4}, 8'h20, 0);
    raise_finish();
    push_expected();
    check("fresh_total", total, 2);
    tick();
    drain(1, -1, sum);
    check("fresh_sum", sum, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Downstream consumer of the LBP stage. It accumulates a 256-bin histogram of LBP codes from the `lbp_valid`/`lbp_data` write stream. Once the LBP stage raises `finish`, it drains all bins in order over a valid/ready interface and then asserts `hist_done`. It sits between the LBP engine and the feature/classifier logic that reads per-frame texture statistics.

## Interface
- `BIN_W`, 8: LBP code width; number of bins is 2^BIN_W.
- `CNT_W`, 14: per-bin and total counter width; one 128x128 frame has at most 15876 codes.
- `ADDR_W`, 14: width of `lbp_addr`.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `lbp_valid`, in, 1: one code is presented this cycle.
- `lbp_addr`, in, ADDR_W: pixel address {y,x}; used only for the border check.
- `lbp_data`, in, BIN_W: LBP code, used as the bin index.
- `finish`, in, 1: LBP stage done; level, held high until reset.
- `hist_valid`, out, 1: `hist_bin`/`hist_count` are valid.
- `hist_ready`, in, 1: downstream accepts the current bin.
- `hist_bin`, out, BIN_W: bin index being drained.
- `hist_count`, out, CNT_W: count for `hist_bin`.
- `total`, out, CNT_W: number of codes accepted into the histogram.
- `border_err`, out, 1: sticky; set if a code arrives with an x or y of 0 or 127.
- `hist_done`, out, 1: all bins drained; held until reset.

## Operation
- States:
  - ACCUM (the reset state).
  - DRAIN.
  - DONE (terminal until reset).
- ACCUM:
  - On each cycle with `lbp_valid`=1, `cnt[lbp_data]` += 1 and `total` += 1.
  - Back-to-back codes are allowed, including repeats of the same bin. There is no read-modify-write hazard because the counters are a register array.
- Saturation: `cnt[i]` and `total` saturate at 2^CNT_W-1 and never wrap.
- Border check: a code whose `lbp_addr[6:0]` or `lbp_addr[13:7]` is 0 or 127 sets `border_err`. That code is still counted.
- ACCUM->DRAIN when `finish`=1. A `lbp_valid` in the same cycle as `finish` is counted.
- DRAIN:
  - Read pointer `rp` starts at 0.
  - `hist_bin`=`rp`, `hist_count`=`cnt[rp]`, and `hist_valid`=1.
  - On `hist_valid`&&`hist_ready`, `rp` += 1 and the outputs reload.
- DRAIN->DONE on acceptance of bin 2^BIN_W-1.
- DONE: `hist_valid`=0 and `hist_done`=1.
- `lbp_valid` is ignored outside ACCUM. It does not change the counts, `total`, or `border_err`.
- Reset at any point clears every counter, the state, and every output in the same edge.

## Timing
- Reset values:
  - `hist_valid`=0, `hist_bin`=0, `hist_count`=0.
  - `total`=0, `border_err`=0, `hist_done`=0.
  - All `cnt[i]`=0; state is ACCUM.
- Count latency: an increment is visible in `cnt`/`total` on the edge after `lbp_valid` is sampled.
- `border_err` rises one cycle after the offending code.
- Drain start: if `finish` is sampled at edge N, then `hist_valid`=1 with bin 0 after edge N+1. The count shown includes any code sampled at edge N.
- All outputs are registered.
- Handshake:
  - `hist_bin`/`hist_count` stay stable while `hist_valid`&&!`hist_ready`.
  - With `hist_ready` held at 1, one bin is accepted per cycle, so the drain takes 256 cycles.
- `hist_done` rises on the edge after bin 255 is accepted, and `hist_valid` falls on that same edge.

## Structure
- Shared package holds:
  - the state enum (ACCUM/DRAIN/DONE);
  - the defaults for BIN_W, CNT_W, ADDR_W;
  - the image border constants (0, 127).
- One sub-module, `sat_inc`: a parameterised saturating +1 incrementer, used for the bin counters and `total`.

## Test plan
- **Basic count:** 3 codes of 0x1F, then `finish`; `hist_ready`=1.
  - Bin 0x1F drains with count 3; every other bin drains 0; `total`=3; `hist_done` after 256 accepts.
- **Same-bin streak:** `lbp_valid` held high for 10 consecutive cycles with code 0xFF.
  - Bin 0xFF=10 and `total`=10; no lost increments.
- **Full frame:** 15876 codes from a 128x128 LBP run with interior addresses only.
  - Sum of drained counts = `total` = 15876; `border_err`=0.
- **Backpressure:** during the drain, `hist_ready` toggles 1,0,0,1 repeatedly.
  - Bin/count stay stable while stalled; bins 0..255 each appear exactly once, in order.
- **Boundary events:**
  - A code 0x80 coincident with `finish` is counted in bin 0x80.
  - A code at `lbp_addr`=0x0000 sets `border_err` and is still counted.
- **Reset mid-drain:** reset asserted at bin 100.
  - All outputs return to reset values the next cycle.
  - A fresh frame then counts from zero.
